scan_chain_shift_ctrl: RTL

Scan-chain driver sitting directly upstream of a chain of scan flip-flops with active-low async set (SE/SI/D/CLK/SETN cells). It serially loads a parallel test pattern into the chain by driving SE and SI, and simultaneously unloads the chain's previous contents from its scan-out into a parallel response register. It can optionally fire one functional capture cycle before signalling completion. Used by the on-chip test controller and by chain-integrity benches.

---
 rtl/scan_ctrl_pkg.sv | 9 +
 rtl/scan_chain_shift_ctrl_sreg.sv | 18 +
 rtl/scan_chain_shift_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared state encoding, scan-enable levels and counter sizing for the scan chain driver.
package scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} scan_state_e;
  localparam logic SE_SHIFT = 1'b1;
  localparam logic SE_FUNC  = 1'b0;
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/scan_chain_shift_ctrl_sreg.sv
// scan_chain_shift_ctrl_sreg: parallel-load right shift register whose serial output is bit 0.
module scan_chain_shift_ctrl_sreg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rn_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic         ser_o
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = load_i ? d_i : shift_i ? q_q >> 1 : q_q;
  always_ff @(posedge clk_i or negedge rn_i)
    if (!rn_i) q_q <= '0;
    else       q_q <= q_d;
  assign ser_o = q_q[0];
endmodule

// File: rtl/scan_chain_shift_ctrl.sv
// scan_chain_shift_ctrl: loads a parallel pattern into a scan chain through SE/SI while unloading
// the previous chain contents from SO, with an optional single functional capture cycle.
module scan_chain_shift_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 cap_req,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 so,
  output logic                 se,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] resp
);
  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam logic [CHAIN_LEN-1:0] ONE = CHAIN_LEN'(1);
  scan_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic se_q, se_d, si_q, si_d, cap_q, cap_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d, bit_sel;
  logic load, shift, ser, last;
  // si already carries pattern[0] from the accept edge, so the register holds the remaining bits
  scan_chain_shift_ctrl_sreg #(.W(CHAIN_LEN)) u_sreg (
    .clk_i  (CLK),
    .rn_i   (RN),
    .load_i (load),
    .shift_i(shift),
    .d_i    (pattern >> 1),
    .ser_o  (ser)
  );
  assign last    = cnt_q == CNT_W'(CHAIN_LEN - 1);
  assign bit_sel = ONE << cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    se_d    = se_q;
    si_d    = si_q;
    cap_d   = cap_q;
    resp_d  = resp_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        se_d = SE_FUNC;
        si_d = 1'b0;
        if (start) begin
          load    = 1'b1;
          cap_d   = cap_req;
          cnt_d   = '0;
          si_d    = pattern[0];
          se_d    = SE_SHIFT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift  = 1'b1;
        resp_d = so ? resp_q | bit_sel : resp_q & ~bit_sel;
        if (last) begin
          cnt_d   = '0;
          se_d    = SE_FUNC;
          si_d    = 1'b0;
          state_d = cap_q ? CAPTURE : DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          si_d  = ser;
        end
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      se_q    <= SE_FUNC;
      si_q    <= 1'b0;
      cap_q   <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      se_q    <= se_d;
      si_q    <= si_d;
      cap_q   <= cap_d;
      resp_q  <= resp_d;
    end
  assign se   = se_q;
  assign si   = si_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign resp = resp_q;
endmodule
